// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   imem_ld_state_t : loader FSM states
//   IMEM_BYTES      : instruction memory size in bytes
//   IMEM_WORDS      : instruction memory size in 32-bit words
//   IMEM_AW         : byte address width
//   LD_SYNC_BYTE    : frame start marker
package imem_loader_pkg;

  localparam int          IMEM_BYTES   = 64;
  localparam int          IMEM_WORDS   = IMEM_BYTES / 4;
  localparam int          IMEM_AW      = $clog2(IMEM_BYTES);
  localparam logic [7:0]  LD_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } imem_ld_state_t;

  // A word count is usable only if it is non-zero and fits in memory.
  function automatic logic len_ok(input logic [7:0] n, input logic [7:0] max_n);
    return (n != 8'd0) && (n <= max_n);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Byte-stream programmer for the instruction memory.
// Accepts a framed image  SYNC, N, 4N payload bytes, CSUM (XOR of payload)
// and writes payload byte k to memory byte address k (big-endian words:
// address 4i holds the MSB of word i).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_data holds a byte
//   in_data    in   stream byte
//   in_ready   out  loader accepts a byte (low only while in reset)
//   mem_we     out  one-cycle byte write strobe
//   mem_addr   out  byte address
//   mem_wdata  out  byte to write
//   core_hold  out  hold the core while a load is in flight or after an error
//   load_done  out  one-cycle pulse on a frame with a good checksum
//   load_err   out  sticky error flag, cleared by the next SYNC byte
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         MEM_BYTES = IMEM_BYTES,
  parameter logic [7:0] SYNC_BYTE = LD_SYNC_BYTE
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [7:0]                   in_data,
  output logic                         in_ready,
  output logic                         mem_we,
  output logic [$clog2(MEM_BYTES)-1:0] mem_addr,
  output logic [7:0]                   mem_wdata,
  output logic                         core_hold,
  output logic                         load_done,
  output logic                         load_err
);

  localparam int         AW        = $clog2(MEM_BYTES);
  localparam int         MAX_WORDS = MEM_BYTES / 4;
  localparam logic [7:0] MAX_N     = 8'(MAX_WORDS);

  imem_ld_state_t state;
  logic [AW-1:0]  byte_cnt;
  logic [AW-1:0]  last_idx;
  logic [7:0]     csum_acc;
  logic           accept;

  assign accept = in_valid && in_ready;

  // Index of the final payload byte, 4N-1. N is already range-checked,
  // so the result always fits in the address width.
  function automatic logic [AW-1:0] last_index(input logic [7:0] n);
    logic [9:0] tmp;
    tmp = {n, 2'b00} - 10'd1;
    return tmp[AW-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      last_idx  <= '0;
      csum_acc  <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      core_hold <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      in_ready  <= 1'b1;
      mem_we    <= 1'b0;
      load_done <= 1'b0;

      case (state)
        // DONE is a one-cycle state but still hunts for SYNC so that a
        // frame starting right after the checksum byte is not lost.
        IDLE, DONE, ERR: begin
          if (accept && in_data == SYNC_BYTE) begin
            state     <= LEN;
            core_hold <= 1'b1;
            load_err  <= 1'b0;
          end else if (state == DONE) begin
            state <= IDLE;
          end
        end

        LEN: begin
          if (accept) begin
            if (len_ok(in_data, MAX_N)) begin
              last_idx <= last_index(in_data);
              byte_cnt <= '0;
              csum_acc <= '0;
              state    <= DATA;
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
            end
          end
        end

        DATA: begin
          if (accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= byte_cnt;
            mem_wdata <= in_data;
            csum_acc  <= csum_acc ^ in_data;
            byte_cnt  <= byte_cnt + AW'(1);
            if (byte_cnt == last_idx) begin
              state <= CSUM;
            end
          end
        end

        CSUM: begin
          if (accept) begin
            if (in_data == csum_acc) begin
              state     <= DONE;
              load_done <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a frame-level reference model runs
// alongside the DUT and every cycle's outputs are compared against it, plus
// hand-computed literal expectations after each directed frame.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       mem_we;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       core_hold;
  logic       load_done;
  logic       load_err;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame parser) ----------------
  bit         m_in_frame = 1'b0;
  logic [7:0] m_fbuf[$];
  logic       m_ready = 1'b0;
  logic       m_we = 1'b0;
  logic       m_done = 1'b0;
  logic       m_hold = 1'b0;
  logic       m_err = 1'b0;
  logic [5:0] m_addr = '0;
  logic [7:0] m_wdata = '0;
  logic [7:0] m_mem[64];

  task automatic model_byte(input logic [7:0] b);
    int k, n, p;
    logic [7:0] x;
    if (!m_in_frame) begin
      if (b == 8'hA5) begin
        m_in_frame = 1'b1;
        m_fbuf.delete();
        m_hold = 1'b1;
        m_err  = 1'b0;
      end
    end else begin
      m_fbuf.push_back(b);
      k = m_fbuf.size();
      n = int'(m_fbuf[0]);
      if (k == 1) begin
        if (n == 0 || n > 16) begin
          m_err = 1'b1;
          m_in_frame = 1'b0;
        end
      end else if (k - 2 < 4 * n) begin
        p = k - 2;
        m_we = 1'b1;
        m_addr = p[5:0];
        m_wdata = b;
        m_mem[p] = b;
      end else begin
        x = 8'h00;
        for (int i = 1; i <= 4 * n; i++) x ^= m_fbuf[i];
        if (b == x) begin
          m_done = 1'b1;
          m_hold = 1'b0;
        end else begin
          m_err = 1'b1;
        end
        m_in_frame = 1'b0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_in_frame = 1'b0;
        m_ready = 1'b0;
        m_we = 1'b0;
        m_done = 1'b0;
        m_hold = 1'b0;
        m_err = 1'b0;
        m_addr = '0;
        m_wdata = '0;
      end else begin
        m_we = 1'b0;
        m_done = 1'b0;
        if (in_valid && m_ready) model_byte(in_data);
        m_ready = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare and memory sniffer ----------------
  logic [7:0] tb_mem[64];
  int         we_cnt = 0;
  int         done_cnt = 0;
  logic [5:0] last_addr = '0;

  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready", in_ready, m_ready);
      chk("mem_we", mem_we, m_we);
      chk("core_hold", core_hold, m_hold);
      chk("load_done", load_done, m_done);
      chk("load_err", load_err, m_err);
      if (m_we) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
      end
      if (mem_we === 1'b1 && !$isunknown(mem_addr)) begin
        tb_mem[mem_addr] = mem_wdata;
        we_cnt++;
        last_addr = mem_addr;
      end
      if (load_done === 1'b1) done_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] b);
    int w = 0;
    while (in_ready !== 1'b1 && w < 10) begin
      in_valid = 1'b0;
      @(negedge clk);
      w++;
    end
    if (in_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: in_ready=%b, expected 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit gaps);
    foreach (f[i]) begin
      if (gaps && $urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      send(f[i]);
    end
    idle(3);
  endtask

  task automatic clr_cnt();
    we_cnt = 0;
    done_cnt = 0;
  endtask

  logic [7:0] frame_ok[$];
  logic [7:0] frame_big[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    frame_ok = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 6'd0);
    chk("rst_mem_wdata", mem_wdata, 8'd0);
    chk("rst_core_hold", core_hold, 1'b0);
    chk("rst_load_done", load_done, 1'b0);
    chk("rst_load_err", load_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1'b1);

    // Valid 2-word frame, with core_hold checked right after SYNC
    clr_cnt();
    send(8'hA5);
    chk("hold_after_sync", core_hold, 1'b1);
    for (int i = 1; i < frame_ok.size(); i++) send(frame_ok[i]);
    idle(3);
    chk("f1_we_cnt", we_cnt, 8);
    chk("f1_done_cnt", done_cnt, 1);
    chk("f1_last_addr", last_addr, 6'd7);
    chk("f1_word1", {tb_mem[4], tb_mem[5], tb_mem[6], tb_mem[7]}, 32'h55667788);
    chk("f1_model_word1", {m_mem[4], m_mem[5], m_mem[6], m_mem[7]}, 32'h55667788);
    chk("f1_word0", {tb_mem[0], tb_mem[1], tb_mem[2], tb_mem[3]}, 32'h11223344);
    chk("f1_hold", core_hold, 1'b0);

    // Bad checksum, then recovery
    clr_cnt();
    send_frame('{8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00}, 1'b0);
    chk("bad_we_cnt", we_cnt, 4);
    chk("bad_done_cnt", done_cnt, 0);
    chk("bad_err", load_err, 1'b1);
    chk("bad_hold", core_hold, 1'b1);
    chk("bad_word0", {tb_mem[0], tb_mem[1], tb_mem[2], tb_mem[3]}, 32'hDEADBEEF);
    clr_cnt();
    send_frame(frame_ok, 1'b0);
    chk("rec_err", load_err, 1'b0);
    chk("rec_hold", core_hold, 1'b0);
    chk("rec_done_cnt", done_cnt, 1);

    // Length errors
    clr_cnt();
    send_frame('{8'hA5, 8'h00}, 1'b0);
    chk("n0_err", load_err, 1'b1);
    chk("n0_we_cnt", we_cnt, 0);
    send_frame('{8'hA5, 8'h11}, 1'b0);
    chk("n17_err", load_err, 1'b1);
    chk("n17_we_cnt", we_cnt, 0);
    chk("n17_hold", core_hold, 1'b1);

    // Full 16-word frame: payload k = 0x40|k, XOR of 0x40..0x7F is 0
    frame_big.delete();
    frame_big.push_back(8'hA5);
    frame_big.push_back(8'h10);
    for (int k = 0; k < 64; k++) frame_big.push_back(8'h40 | 8'(k));
    frame_big.push_back(8'h00);
    clr_cnt();
    send_frame(frame_big, 1'b0);
    chk("big_we_cnt", we_cnt, 64);
    chk("big_last_addr", last_addr, 6'd63);
    chk("big_mem0", tb_mem[0], 8'h40);
    chk("big_mem63", tb_mem[63], 8'h7F);
    chk("big_done_cnt", done_cnt, 1);
    chk("big_err", load_err, 1'b0);

    // Junk before SYNC, then the valid frame with random gaps
    clr_cnt();
    for (int i = 0; i < 8; i++) tb_mem[i] = 8'h00;
    send(8'h00);
    send(8'hFF);
    idle(2);
    chk("junk_hold", core_hold, 1'b0);
    chk("junk_we_cnt", we_cnt, 0);
    send_frame(frame_ok, 1'b1);
    chk("gap_we_cnt", we_cnt, 8);
    chk("gap_done_cnt", done_cnt, 1);
    chk("gap_word0", {tb_mem[0], tb_mem[1], tb_mem[2], tb_mem[3]}, 32'h11223344);
    chk("gap_word1", {tb_mem[4], tb_mem[5], tb_mem[6], tb_mem[7]}, 32'h55667788);

    // Payload bytes equal to SYNC are data: csum A5^A5^12^34 = 26
    clr_cnt();
    send_frame('{8'hA5, 8'h01, 8'hA5, 8'hA5, 8'h12, 8'h34, 8'h26}, 1'b0);
    chk("a5_mem0", tb_mem[0], 8'hA5);
    chk("a5_mem1", tb_mem[1], 8'hA5);
    chk("a5_we_cnt", we_cnt, 4);
    chk("a5_done_cnt", done_cnt, 1);

    // Asynchronous reset mid-DATA after 3 payload bytes
    clr_cnt();
    send(8'hA5);
    send(8'h02);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_mem_we", mem_we, 1'b0);
    chk("mid_rst_mem_addr", mem_addr, 6'd0);
    chk("mid_rst_mem_wdata", mem_wdata, 8'd0);
    chk("mid_rst_hold", core_hold, 1'b0);
    chk("mid_rst_err", load_err, 1'b0);
    chk("mid_rst_done", load_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("pre_rst_mem2", tb_mem[2], 8'h03);
    clr_cnt();
    // csum C0^FF^EE^01 = D0
    send_frame('{8'hA5, 8'h01, 8'hC0, 8'hFF, 8'hEE, 8'h01, 8'hD0}, 1'b0);
    chk("post_rst_word0", {tb_mem[0], tb_mem[1], tb_mem[2], tb_mem[3]}, 32'hC0FFEE01);
    chk("post_rst_we_cnt", we_cnt, 4);
    chk("post_rst_done_cnt", done_cnt, 1);
    chk("post_rst_hold", core_hold, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream programmer for the 64-byte instruction memory. Receives a framed program image over a valid/ready byte interface, typically from a UART receiver, validates it, and drives the memory's byte write port. Image bytes are stored in the same big-endian layout the fetch path reads: the instruction MSB is at word address ×4. While a load is in flight, the core is held off via `core_hold`.

## Interface
Parameters:
- `MEM_BYTES`, 64: instruction memory size in bytes; must be a multiple of 4; `MAX_WORDS = MEM_BYTES/4` (16).
- `SYNC_BYTE`, 8'hA5: frame start marker.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  `in_data` holds a byte.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  byte write strobe to instruction memory.
- `mem_addr`  out  6  byte address (`$clog2(MEM_BYTES)`).
- `mem_wdata`  out  8  byte to write.
- `core_hold`  out  1  stall/reset request to the core.
- `load_done`  out  1  one-cycle pulse when a frame completes with a good checksum.
- `load_err`  out  1  sticky error flag.

## Operation
- Frame format: `SYNC_BYTE`, then `N` (word count), then `4N` payload bytes, then `CSUM`, where CSUM is the XOR of all payload bytes.
- A byte is accepted only in a cycle where `in_valid && in_ready`. `in_ready` is 1 in every state except while held in reset.
- FSM states are IDLE, LEN, DATA, CSUM, DONE and ERR.
  - IDLE: an accepted `SYNC_BYTE` moves to LEN, sets `core_hold=1` and clears `load_err`. Other bytes are discarded.
  - LEN: if `N==0` or `N>MAX_WORDS`, go to ERR. Otherwise latch `N`, clear `byte_cnt` and `csum_acc`, and go to DATA.
  - DATA: each accepted byte is written to address `byte_cnt`. The loader updates `csum_acc ^= byte` and increments `byte_cnt`. When the accepted byte has `byte_cnt == 4N-1`, go to CSUM.
  - CSUM: if the accepted byte equals `csum_acc`, go to DONE. Otherwise go to ERR.
  - DONE: lasts one cycle. `load_done=1` and `core_hold` falls to 0. The FSM then returns to IDLE.
  - ERR: `load_err=1` and `core_hold` stays 1, because the memory contents are now suspect. An accepted `SYNC_BYTE` restarts at LEN and clears `load_err`. Other bytes are discarded.
- Payload bytes equal to `SYNC_BYTE` inside DATA or CSUM are ordinary data. There is no escaping and no resync mid-frame.
- Byte k of the payload goes to address k. Word i occupies addresses 4i (MSB) through 4i+3 (LSB).
- Addresses never exceed `4*MAX_WORDS-1` because of the LEN check. There is no address wrap.
- Memory bytes beyond `4N` are not touched.

## Timing
- Reset values: `in_ready=0` during reset, then 1. `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `core_hold=0`, `load_done=0`, `load_err=0`. State is IDLE.
- All outputs are registered. `mem_we`, `mem_addr` and `mem_wdata` appear on the cycle after the byte is accepted, with latency 1. `mem_we` lasts exactly one cycle per byte.
- Back-to-back bytes, one per cycle, are supported at full rate with no bubbles.
- Gaps (`in_valid=0`) are allowed in any state. The FSM holds state and there is no timeout.
- `core_hold` rises in the cycle after the `SYNC_BYTE` is accepted.
- `load_done` and the fall of `core_hold` occur in the cycle after the CSUM byte is accepted.
- After the last payload byte, its `mem_we` is issued before `load_done`.
- `load_err` rises in the cycle after the offending LEN or CSUM byte is accepted.
- Reset mid-frame clears all state immediately and asynchronously. `core_hold` drops to 0. Bytes already written stay in memory; no rollback.

## Structure
- Shared package holds:
  - the state enum `imem_ld_state_t` (IDLE, LEN, DATA, CSUM, DONE, ERR);
  - the constants `IMEM_BYTES=64`, `IMEM_WORDS=16`, `LD_SYNC_BYTE=8'hA5`;
  - the address width `IMEM_AW=6`.
- Single module. No sub-module is needed; the checksum accumulator and byte counter are inline registers.

## Test plan
- Valid 2-word frame `A5 02 11 22 33 44 55 66 77 88 88` → writes 0x11..0x88 to addresses 0..7 on consecutive cycles, then `load_done` pulses once. Reading word 1 returns 0x55667788. `core_hold` is 1 from the cycle after A5 until `load_done`.
- Bad checksum: `A5 01 DE AD BE EF 00` → 4 writes, no `load_done`, `load_err=1`, `core_hold` stays 1. Then a valid frame clears `load_err` and drops `core_hold`.
- Length errors: `N=0x00` and `N=0x11` each → ERR immediately with zero `mem_we` pulses. A following `A5 10 …` with 64 bytes and a correct checksum fills addresses 0..63, and the last address is 63.
- Junk and gaps: `00 FF A5` in IDLE is ignored until A5. Random `in_valid` gaps inside DATA → same writes and addresses as the gapless run. A payload byte `A5` is written as data.
- `rst_n` asserted mid-DATA after 3 bytes → all outputs go to reset values at once and state is IDLE. A new frame then loads correctly from address 0.
